// File: rtl/lockstep_pkg.sv
// Shared types for the two-copy lockstep run sequencer.
// State encoding and its width live here.
package lockstep_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_WAIT_1 = 3'd2,
    S_WAIT_2 = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lockstep_sequencer.sv
// Lockstep run sequencer: freezes the first core to retire until its twin
// retires, gates fetch past the program end, and detects drain or desync.
module lockstep_sequencer
  import lockstep_pkg::*;
#(
  parameter logic [31:0] END_ADDR     = 32'h0000_0100,
  parameter int          MAX_STALL    = 64,
  parameter int          DRAIN_CYCLES = 8,
  parameter int          CTR_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             retire_1_i,
  input  logic             retire_2_i,
  input  logic [31:0]      instr_addr_1_i,
  input  logic [31:0]      instr_addr_2_i,
  output logic             clk_en_1_o,
  output logic             clk_en_2_o,
  output logic             fetch_en_1_o,
  output logic             fetch_en_2_o,
  output logic             retire_o,
  output logic [CTR_W-1:0] retire_cnt_o,
  output logic             finished_o,
  output logic             desync_o
);

  localparam int SW = $clog2(MAX_STALL + 1);
  localparam int DW =
    (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [SW-1:0] STALL_LAST = SW'(MAX_STALL - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);

  state_e state_q;
  state_e state_d;

  logic fetch_1_q;
  logic fetch_1_d;
  logic fetch_2_q;
  logic fetch_2_d;

  logic clk_en_1;
  logic clk_en_2;
  logic retire;

  logic stall_inc;
  logic stall_clr;
  logic drain_inc;
  logic drain_clr;
  logic gates_shut;

  logic [SW-1:0] stall_cnt;
  logic [DW-1:0] drain_cnt;

  assign gates_shut = !fetch_1_q && !fetch_2_q;
  assign drain_clr  = (state_q == S_IDLE);

  // sequencing FSM: next state, clock enables and pair strobe
  always_comb begin
    state_d   = state_q;
    clk_en_1  = 1'b0;
    clk_en_2  = 1'b0;
    retire    = 1'b0;
    stall_inc = 1'b0;
    stall_clr = 1'b1;
    drain_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        clk_en_1  = 1'b1;
        clk_en_2  = 1'b1;
        drain_inc = gates_shut && (drain_cnt != DRAIN_LAST);
        if (gates_shut && (drain_cnt == DRAIN_LAST) &&
            !retire_1_i && !retire_2_i) begin
          state_d = S_DONE;
        end else if (retire_1_i && retire_2_i) begin
          retire = 1'b1;
        end else if (retire_1_i) begin
          clk_en_1 = 1'b0;
          state_d  = S_WAIT_1;
        end else if (retire_2_i) begin
          clk_en_2 = 1'b0;
          state_d  = S_WAIT_2;
        end
      end
      S_WAIT_1: begin
        clk_en_2  = 1'b1;
        stall_clr = 1'b0;
        if (retire_2_i) begin
          clk_en_1  = 1'b1;
          retire    = 1'b1;
          stall_clr = 1'b1;
          state_d   = S_RUN;
        end else if (stall_cnt == STALL_LAST) begin
          state_d = S_ERROR;
        end else begin
          stall_inc = 1'b1;
        end
      end
      S_WAIT_2: begin
        clk_en_1  = 1'b1;
        stall_clr = 1'b0;
        if (retire_1_i) begin
          clk_en_2  = 1'b1;
          retire    = 1'b1;
          stall_clr = 1'b1;
          state_d   = S_RUN;
        end else if (stall_cnt == STALL_LAST) begin
          state_d = S_ERROR;
        end else begin
          stall_inc = 1'b1;
        end
      end
      S_DONE: begin
      end
      S_ERROR: begin
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // fetch gates: open on start, close once a running core passes the end
  always_comb begin
    fetch_1_d = fetch_1_q;
    fetch_2_d = fetch_2_q;
    if ((state_q == S_IDLE) && start_i) begin
      fetch_1_d = 1'b1;
      fetch_2_d = 1'b1;
    end
    if (clk_en_1 && (instr_addr_1_i >= END_ADDR)) begin
      fetch_1_d = 1'b0;
    end
    if (clk_en_2 && (instr_addr_2_i >= END_ADDR)) begin
      fetch_2_d = 1'b0;
    end
    if (state_d == S_ERROR) begin
      fetch_1_d = 1'b0;
      fetch_2_d = 1'b0;
    end
  end

  // fetch gate registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_1_q <= 1'b0;
      fetch_2_q <= 1'b0;
    end else begin
      fetch_1_q <= fetch_1_d;
      fetch_2_q <= fetch_2_d;
    end
  end

  sat_counter #(
    .W (CTR_W)
  ) u_retire_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (retire),
    .clr_i  (1'b0),
    .cnt_o  (retire_cnt_o)
  );

  sat_counter #(
    .W (SW)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_inc),
    .clr_i  (stall_clr),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(
    .W (DW)
  ) u_drain_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (drain_inc),
    .clr_i  (drain_clr),
    .cnt_o  (drain_cnt)
  );

  assign clk_en_1_o   = clk_en_1;
  assign clk_en_2_o   = clk_en_2;
  assign retire_o     = retire;
  assign fetch_en_1_o = fetch_1_q;
  assign fetch_en_2_o = fetch_2_q;
  assign finished_o   = (state_q == S_DONE);
  assign desync_o     = (state_q == S_ERROR);

endmodule

// File: tb/tb_lockstep_sequencer.sv
// Scoreboard bench for lockstep_sequencer: directed scenarios plus
// randomized episodes checked against a behavioural run model.
module tb_lockstep_sequencer;

  localparam logic [31:0] END_A = 32'h0000_0100;
  localparam int MAXS = 4;
  localparam int DRN  = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic r1    = 1'b0;
  logic r2    = 1'b0;
  logic [31:0] a1 = '0;
  logic [31:0] a2 = '0;

  logic          clk_en_1;
  logic          clk_en_2;
  logic          fetch_en_1;
  logic          fetch_en_2;
  logic          retire;
  logic [CW-1:0] retire_cnt;
  logic          finished;
  logic          desync;

  typedef struct packed {
    logic          e1;
    logic          e2;
    logic          f1;
    logic          f2;
    logic          ret;
    logic          fin;
    logic          des;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural run model
  bit m_on;
  bit m_done;
  bit m_err;
  bit m_open1;
  bit m_open2;
  int m_frz;
  int m_wait;
  int m_drain;
  int m_pairs;

  always #5 clk = ~clk;

  lockstep_sequencer #(
    .END_ADDR     (END_A),
    .MAX_STALL    (MAXS),
    .DRAIN_CYCLES (DRN),
    .CTR_W        (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .retire_1_i     (r1),
    .retire_2_i     (r2),
    .instr_addr_1_i (a1),
    .instr_addr_2_i (a2),
    .clk_en_1_o     (clk_en_1),
    .clk_en_2_o     (clk_en_2),
    .fetch_en_1_o   (fetch_en_1),
    .fetch_en_2_o   (fetch_en_2),
    .retire_o       (retire),
    .retire_cnt_o   (retire_cnt),
    .finished_o     (finished),
    .desync_o       (desync)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: every presented cycle is checked against the scoreboard
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("clk_en_1", 32'(clk_en_1), 32'(mon_e.e1));
      chk("clk_en_2", 32'(clk_en_2), 32'(mon_e.e2));
      chk("fetch_en_1", 32'(fetch_en_1), 32'(mon_e.f1));
      chk("fetch_en_2", 32'(fetch_en_2), 32'(mon_e.f2));
      chk("retire", 32'(retire), 32'(mon_e.ret));
      chk("retire_cnt", 32'(retire_cnt), 32'(mon_e.cnt));
      chk("finished", 32'(finished), 32'(mon_e.fin));
      chk("desync", 32'(desync), 32'(mon_e.des));
    end
  end

  function automatic void model_reset();
    m_on    = 0;
    m_done  = 0;
    m_err   = 0;
    m_open1 = 0;
    m_open2 = 0;
    m_frz   = 0;
    m_wait  = 0;
    m_drain = 0;
    m_pairs = 0;
  endfunction

  // drive one cycle, push its expected response, advance the model
  task automatic cyc(input logic s, input logic x1, input logic x2,
                     input logic [31:0] p1, input logic [31:0] p2);
    exp_t e;
    bit live;
    bit shut;
    bit partner;
    @(posedge clk);
    #1;
    start = s;
    r1    = x1;
    r2    = x2;
    a1    = p1;
    a2    = p2;
    live  = m_on && !m_done && !m_err;
    e.e1  = 1'b0;
    e.e2  = 1'b0;
    e.ret = 1'b0;
    if (live) begin
      if (m_frz == 0) begin
        e.e1  = !(x1 && !x2);
        e.e2  = !(x2 && !x1);
        e.ret = x1 && x2;
      end else if (m_frz == 1) begin
        e.e1  = x2;
        e.e2  = 1'b1;
        e.ret = x2;
      end else begin
        e.e1  = 1'b1;
        e.e2  = x1;
        e.ret = x1;
      end
    end
    e.f1  = m_open1;
    e.f2  = m_open2;
    e.fin = m_done;
    e.des = m_err;
    e.cnt = (m_pairs > CMAX) ? CW'(CMAX) : CW'(m_pairs);
    q.push_back(e);
    if (!m_on) begin
      if (s) begin
        m_on    = 1;
        m_open1 = 1;
        m_open2 = 1;
      end
    end else if (live) begin
      shut = !m_open1 && !m_open2;
      if (e.ret) m_pairs++;
      if (e.e1 && p1 >= END_A) m_open1 = 0;
      if (e.e2 && p2 >= END_A) m_open2 = 0;
      if (m_frz == 0) begin
        if (shut && m_drain == DRN && !x1 && !x2) begin
          m_done = 1;
        end else begin
          if (shut && m_drain < DRN) m_drain++;
          if (x1 && !x2) begin
            m_frz  = 1;
            m_wait = 0;
          end else if (x2 && !x1) begin
            m_frz  = 2;
            m_wait = 0;
          end
        end
      end else begin
        partner = (m_frz == 1) ? x2 : x1;
        if (partner) begin
          m_frz  = 0;
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait >= MAXS) begin
            m_err   = 1;
            m_open1 = 0;
            m_open2 = 0;
          end
        end
      end
    end
  endtask

  // asynchronous reset: everything must drop before the next edge
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    r1    = 1'b0;
    r2    = 1'b0;
    a1    = '0;
    a2    = '0;
    #1;
    chk("rst_clk_en_1", 32'(clk_en_1), 32'd0);
    chk("rst_clk_en_2", 32'(clk_en_2), 32'd0);
    chk("rst_fetch_en_1", 32'(fetch_en_1), 32'd0);
    chk("rst_fetch_en_2", 32'(fetch_en_2), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_desync", 32'(desync), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] base;
    logic x1;
    logic x2;
    model_reset();
    do_reset();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    // paired retires on cycles 3, 5, 7
    for (int i = 0; i < 9; i++) begin
      x1 = (i == 3 || i == 5 || i == 7);
      cyc(1, x1, x1, 32'h10, 32'h10);
    end
    // core 1 at cycle 4, core 2 at cycle 7
    for (int i = 0; i < 10; i++) begin
      cyc(1, i == 4, i == 7, 32'h20, 32'h20);
    end
    // core 2 retires, core 1 never follows
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, i == 2, 32'h30, 32'h30);
    end
    do_reset();
    // reset while core 1 is frozen, then restart
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    do_reset();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 32'h8, 32'h8);
    // saturation of the pair counter
    for (int i = 0; i < 18; i++) cyc(1, 1, 1, 32'h40, 32'h40);
    cyc(1, 0, 0, 32'h40, 32'h40);
    // both programs end, drain to finish
    cyc(1, 0, 0, 32'h100, 32'h100);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0, 32'h0, 32'h0);
    // randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int i = 0; i < $urandom_range(0, 3); i++) cyc(0, 0, 0, 0, 0);
      base = $urandom_range(32'h60, 32'hE0);
      for (int i = 0; i < 160; i++) begin
        x1 = ($urandom_range(0, 3) == 0);
        x2 = ($urandom_range(0, 9) < 4) ? x1 : ($urandom_range(0, 3) == 0);
        cyc(1, x1, x2, base + 32'(i),
            base + 32'(i) + 32'($urandom_range(0, 3)));
      end
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
